// File: rtl/seg7_mux_scan.sv
// Multiplexed hex 7-segment scanner: tear-free frame update, leading-zero suppression, blank, blink.
// Latency: pins are registered one cycle behind idx; loaded data reaches the pins one cycle after the next frame wrap.
// Backpressure: none; load is taken every cycle and the newest shadow value wins at the frame wrap.
module seg7_mux_scan #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLINK_LOG2   = 5,
    parameter int COMMON_ANODE = 0,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] value_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    input  logic                blank,
    input  logic                blink_en,
    output logic [6:0]          segments,
    output logic                dp,
    output logic [DIGITS-1:0]   digit_en,
    output logic                frame_tick
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
    localparam logic              INV       = (COMMON_ANODE != 0);

    // One displayable frame: per-digit decimal points above the packed nibbles.
    typedef struct packed {
        logic [DIGITS-1:0]   dps;
        logic [4*DIGITS-1:0] nibs;
    } frame_t;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    frame_t                shadow_q, shadow_d, disp_q;
    logic                  primed_q;
    logic [PCNT_W-1:0]     pcnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [BLINK_LOG2-1:0] fcnt_q;
    logic                  phase_q;
    logic                  wrap_d_q;
    logic                  slot_end, wrap, dark;
    logic                  zero_above;
    logic [DIGITS-1:0]     lz_blank;
    logic [3:0]            nib;
    logic [6:0]            seg_d, seg_q;
    logic                  dp_d, dp_q;
    logic [DIGITS-1:0]     en_d, en_q;

    // The copy into the display register sees this cycle's load, so a load on the wrap cycle is not lost.
    assign shadow_d = load ? frame_t'({dp_in, value_in}) : shadow_q;
    assign slot_end = primed_q && (pcnt_q == PCNT_LAST);
    assign wrap     = slot_end && (idx_q == IDX_LAST);
    assign dark     = blank || (blink_en && phase_q);

    // Shadow register follows load unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_q <= '0;
        else        shadow_q <= shadow_d;
    end

    // Display register only changes between frames (and once right after reset) so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 disp_q <= '0;
        else if (!primed_q || wrap) disp_q <= shadow_d;
    end

    // First cycle after reset primes the display register; scanning starts on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) primed_q <= 1'b0;
        else        primed_q <= 1'b1;
    end

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            idx_q  <= '0;
        end else if (slot_end) begin
            pcnt_q <= '0;
            idx_q  <= wrap ? '0 : idx_q + IDX_W'(1);
        end else if (primed_q) begin
            pcnt_q <= pcnt_q + PCNT_W'(1);
        end
    end

    // Frame counter and blink phase keep running whether or not blinking is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (wrap) begin
            fcnt_q <= fcnt_q + BLINK_LOG2'(1);
            if (&fcnt_q) phase_q <= ~phase_q;
        end
    end

    // frame_tick is delayed one extra stage so it lines up with digit 0 appearing on the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_d_q   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            wrap_d_q   <= wrap;
            frame_tick <= wrap_d_q;
        end
    end

    // Leading-zero mask: a digit above 0 is blank when it and everything above it is zero.
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (disp_q.nibs[4*i +: 4] == 4'h0);
            lz_blank[i] = (i > 0) && zero_above && (LZ_SUPPRESS != 0);
        end
    end

    // Next logical pin levels for the digit currently selected by idx.
    always_comb begin
        seg_d = 7'h00;
        dp_d  = 1'b0;
        en_d  = '0;
        nib   = disp_q.nibs[4*int'(idx_q) +: 4];
        if (primed_q && !dark) begin
            en_d  = DIGITS'(1) << idx_q;
            dp_d  = disp_q.dps[int'(idx_q)];
            seg_d = lz_blank[int'(idx_q)] ? 7'h00 : hex7(nib);
        end
    end

    // Output register holds logical levels; reset value is all-inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
            en_q  <= '0;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            en_q  <= en_d;
        end
    end

    // Polarity is a constant XOR, so pins cannot glitch active when the registers clear.
    assign segments = seg_q ^ {7{INV}};
    assign dp       = dp_q ^ INV;
    assign digit_en = en_q ^ {DIGITS{INV}};

endmodule

// File: tb/tb_seg7_mux_scan.sv
module tb_seg7_mux_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_a;
    logic [3:0]  dp_a;
    logic        load, blank, blink_en;
    logic [6:0]  seg_a;
    logic        dp_o_a;
    logic [3:0]  en_a;
    logic        ft_a;

    logic [3:0]  value_b = 4'h8;
    logic        dp_b    = 1'b0;
    logic        blank_b = 1'b0;
    logic        blink_b = 1'b0;
    logic [6:0]  seg_b;
    logic        dp_o_b;
    logic        en_b;
    logic        ft_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seg7_mux_scan #(.DIGITS(4), .PRESCALE(3), .BLINK_LOG2(1), .COMMON_ANODE(0), .LZ_SUPPRESS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .value_in(value_a), .dp_in(dp_a), .load(load),
        .blank(blank), .blink_en(blink_en), .segments(seg_a), .dp(dp_o_a),
        .digit_en(en_a), .frame_tick(ft_a)
    );

    seg7_mux_scan #(.DIGITS(1), .PRESCALE(2), .BLINK_LOG2(1), .COMMON_ANODE(1), .LZ_SUPPRESS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .value_in(value_b), .dp_in(dp_b), .load(load),
        .blank(blank_b), .blink_en(blink_b), .segments(seg_b), .dp(dp_o_b),
        .digit_en(en_b), .frame_tick(ft_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: compare one expected item per clock, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check($sformatf("digit_en@%0d", mon_e.cyc), {28'd0, en_a}, {28'd0, mon_e.en});
            check($sformatf("segments@%0d", mon_e.cyc), {25'd0, seg_a}, {25'd0, mon_e.seg});
            check($sformatf("dp@%0d", mon_e.cyc), {31'd0, dp_o_a}, {31'd0, mon_e.dp});
            check($sformatf("frame_tick@%0d", mon_e.cyc), {31'd0, ft_a}, {31'd0, mon_e.ft});
        end
    end

    initial begin
        logic [19:0] shadow_m;
        logic [19:0] disp_m;
        exp_t        e;
        int          d, f, m;
        logic        off;

        rst_n    = 1'b0;
        load     = 1'b0;
        blank    = 1'b0;
        blink_en = 1'b0;
        value_a  = 16'h1234;
        dp_a     = 4'b0000;
        shadow_m = '0;
        disp_m   = '0;

        #2;
        check("rst_a_seg", {25'd0, seg_a}, 32'h00);
        check("rst_a_en",  {28'd0, en_a},  32'h0);
        check("rst_a_dp",  {31'd0, dp_o_a}, 32'h0);
        check("rst_a_ft",  {31'd0, ft_a},  32'h0);
        check("rst_b_seg", {25'd0, seg_b}, 32'h7F);
        check("rst_b_en",  {31'd0, en_b},  32'h1);
        check("rst_b_dp",  {31'd0, dp_o_b}, 32'h1);

        @(negedge clk);
        rst_n = 1'b1;

        // n = index of the upcoming rising edge since reset release.
        for (int n = 1; n <= 125; n++) begin
            load = 1'b0;
            case (n)
                1:  begin load = 1'b1; value_a = 16'h1234; dp_a = 4'b0000; end
                16: begin load = 1'b1; value_a = 16'hABCD; dp_a = 4'b0000; end
                32: begin load = 1'b1; value_a = 16'h0000; dp_a = 4'b0000; end
                40: begin load = 1'b1; value_a = 16'h0050; dp_a = 4'b1000; end
                61: begin load = 1'b1; value_a = 16'h9876; dp_a = 4'b0000; end
                default: ;
            endcase
            blink_en = (n >= 62) && (n <= 109);
            blank    = (n >= 110) && (n <= 115);

            e.cyc = n;
            e.en  = 4'b0000;
            e.seg = 7'h00;
            e.dp  = 1'b0;
            e.ft  = 1'b0;
            if (n >= 2) begin
                d    = ((n - 2) / 3) % 4;
                f    = (n - 2) / 12;
                e.ft = (n >= 14) && ((n - 2) % 12 == 0);
                off  = blank || (blink_en && (((f >> 1) & 1) == 1));
                if (!off) begin
                    e.en = 4'b0001 << d;
                    e.dp = disp_m[16 + d];
                    if (d > 0 && ((disp_m[15:0] >> (4 * d)) == 16'h0)) e.seg = 7'h00;
                    else e.seg = hex_tab[disp_m[4*d +: 4]];
                end
            end
            sb_q.push_back(e);

            if (load) shadow_m = {dp_a, value_a};
            if (n == 1 || (n >= 13 && (n - 1) % 12 == 0)) disp_m = shadow_m;

            // Single-digit common-anode instance, result of edge n-1.
            m = n - 1;
            if (m >= 1 && m <= 6) begin
                check($sformatf("b_seg@%0d", m), {25'd0, seg_b}, (m >= 2) ? 32'h00 : 32'h7F);
                check($sformatf("b_en@%0d", m),  {31'd0, en_b},  (m >= 2) ? 32'h0 : 32'h1);
                check($sformatf("b_dp@%0d", m),  {31'd0, dp_o_b}, 32'h1);
                check($sformatf("b_ft@%0d", m),  {31'd0, ft_b},  (m >= 4 && m % 2 == 0) ? 32'h1 : 32'h0);
            end

            @(negedge clk);
        end

        check("sb_drain", sb_q.size(), 32'd0);

        // Reset asserted between edges must clear outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_seg", {25'd0, seg_a}, 32'h00);
        check("mid_rst_a_en",  {28'd0, en_a},  32'h0);
        check("mid_rst_a_dp",  {31'd0, dp_o_a}, 32'h0);
        check("mid_rst_a_ft",  {31'd0, ft_a},  32'h0);
        check("mid_rst_b_seg", {25'd0, seg_b}, 32'h7F);
        check("mid_rst_b_en",  {31'd0, en_b},  32'h1);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_edge1_en", {28'd0, en_a}, 32'h0);
        @(posedge clk);
        #1;
        check("rel_edge2_en",  {28'd0, en_a},  32'h1);
        check("rel_edge2_seg", {25'd0, seg_a}, 32'h3F);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
